// File: rtl/lzd_seq_pkg.sv
// Shared types and default sizing for the sequential leading-zero detector
// and its per-word priority encoder.
package lzd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WORD_W    = 16;
  localparam int DEF_MAX_WORDS = 4;
  localparam int DEF_CNT_W     = 7;

  function automatic int satCount(input int wordW, input int maxWords);
    return wordW * maxWords;
  endfunction

  // Count reported when every word of the virtual word is zero.
  localparam int SAT_COUNT = DEF_WORD_W * DEF_MAX_WORDS;

  function automatic int clog2Min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/lzd_word.sv
// Combinational priority encoder: leading-zero count and zero flag of one word.
module lzd_word
  import lzd_seq_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LZ_W   = clog2Min1(DEF_WORD_W)
) (
  input  logic [WORD_W-1:0] word_i,
  output logic [LZ_W-1:0]   lz_o,
  output logic              zero_o
);

  // Scanning upward lets the highest set bit overwrite all lower candidates.
  always_comb begin
    lz_o = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (word_i[i]) begin
        lz_o = LZ_W'(WORD_W - 1 - i);
      end
    end
  end

  assign zero_o = ~|word_i;

endmodule

// File: rtl/lzd_seq.sv
// Sequential leading-zero detector over up to MAX_WORDS random words
// concatenated MSB-first; reports count, left-aligned fraction and all-zero flag.
module lzd_seq
  import lzd_seq_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] rnd_in,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  output logic [CNT_W-1:0]  LZDout,
  output logic [WORD_W-2:0] frac,
  output logic              all_zero,
  output logic              busy,
  output logic              done
);

  localparam int LZ_W    = clog2Min1(WORD_W);
  localparam int IDX_W   = clog2Min1(MAX_WORDS);
  localparam int SAT_CNT = satCount(WORD_W, MAX_WORDS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  lzd_q, lzd_d;
  logic [WORD_W-2:0] frac_q, frac_d;
  logic              allZero_q, allZero_d;

  logic [LZ_W-1:0]   wordLz;
  logic              wordZero;
  logic [WORD_W-1:0] shifted;
  logic              accept;

  lzd_word #(
    .WORD_W (WORD_W),
    .LZ_W   (LZ_W)
  ) u_lzd_word (
    .word_i (rnd_in),
    .lz_o   (wordLz),
    .zero_o (wordZero)
  );

  // Shifting by lz puts the leading one at the MSB; the bits beneath it are the fraction.
  assign shifted = rnd_in << wordLz;
  assign accept  = rnd_valid && (state_q == SCAN);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    lzd_d     = lzd_q;
    frac_d    = frac_q;
    allZero_d = allZero_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SCAN;
          count_d = '0;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (accept) begin
          if (!wordZero) begin
            lzd_d     = count_q + CNT_W'(wordLz);
            frac_d    = shifted[WORD_W-2:0];
            allZero_d = 1'b0;
            state_d   = DONE;
          end else begin
            count_d = count_q + CNT_W'(WORD_W);
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(MAX_WORDS - 1)) begin
              lzd_d     = CNT_W'(SAT_CNT);
              frac_d    = '0;
              allZero_d = 1'b1;
              state_d   = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      lzd_q     <= '0;
      frac_q    <= '0;
      allZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      lzd_q     <= lzd_d;
      frac_q    <= frac_d;
      allZero_q <= allZero_d;
    end
  end

  assign rnd_ready = (state_q == SCAN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign LZDout    = lzd_q;
  assign frac      = frac_q;
  assign all_zero  = allZero_q;

endmodule

// File: tb/tb_lzd_seq.sv
// Table-driven bench for lzd_seq with a result scoreboard popped on each done pulse.
module tb_lzd_seq;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] rnd_in;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [6:0]  LZDout;
  logic [14:0] frac;
  logic        all_zero;
  logic        busy;
  logic        done;

  typedef struct packed {
    int             nWords;
    logic [3:0][15:0] words;
    int             stall;
    logic [6:0]     lzd;
    logic [14:0]    frac;
    logic           allZero;
  } vec_t;

  typedef struct packed {
    logic [6:0]  lzd;
    logic [14:0] frac;
    logic        allZero;
  } exp_t;

  exp_t expQ[$];
  vec_t vecs[8];
  vec_t vecAfterReset;
  int   checks = 0;
  int   passes = 0;

  lzd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rnd_in    (rnd_in),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .LZDout    (LZDout),
    .frac      (frac),
    .all_zero  (all_zero),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mkVec(input int n, input logic [15:0] w0, input logic [15:0] w1,
                                 input logic [15:0] w2, input logic [15:0] w3, input int stall,
                                 input logic [6:0] lzd, input logic [14:0] fr, input logic az);
    vec_t v;
    v.nWords   = n;
    v.words[0] = w0;
    v.words[1] = w1;
    v.words[2] = w2;
    v.words[3] = w3;
    v.stall    = stall;
    v.lzd      = lzd;
    v.frac     = fr;
    v.allZero  = az;
    return v;
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_done: done=1, expected no result at %0t", $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("lzd", 32'(LZDout), 32'(e.lzd));
        checkOutput("frac", 32'(frac), 32'(e.frac));
        checkOutput("all_zero", 32'(all_zero), 32'(e.allZero));
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    @(posedge clk); #1;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      $display("[TB] FAIL idle_timeout: busy=1, expected 0 at %0t", $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    waitIdle();
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    e.lzd     = v.lzd;
    e.frac    = v.frac;
    e.allZero = v.allZero;
    expQ.push_back(e);
    for (int s = 0; s < v.stall; s++) begin
      rnd_valid = 1'b0;
      @(negedge clk);
      checkOutput("ready_stall", 32'(rnd_ready), 32'd1);
      @(posedge clk); #1;
    end
    for (int w = 0; w < v.nWords; w++) begin
      rnd_in    = v.words[w];
      rnd_valid = 1'b1;
      @(negedge clk);
      checkOutput("ready_scan", 32'(rnd_ready), 32'd1);
      @(posedge clk); #1;
    end
    rnd_in    = 16'hFFFF;
    rnd_valid = 1'b1;
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("ready_in_done", 32'(rnd_ready), 32'd0);
    @(posedge clk); #1;
    rnd_valid = 1'b0;
    @(negedge clk);
    checkOutput("done_single", 32'(done), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    vecs[0] = mkVec(1, 16'h2ABC, 16'h0, 16'h0, 16'h0, 0, 7'd2,  15'h2AF0, 1'b0);
    vecs[1] = mkVec(2, 16'h0000, 16'h0001, 16'h0, 16'h0, 0, 7'd31, 15'h0000, 1'b0);
    vecs[2] = mkVec(4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 7'd64, 15'h0000, 1'b1);
    vecs[3] = mkVec(1, 16'h8000, 16'h0, 16'h0, 16'h0, 3, 7'd0,  15'h0000, 1'b0);
    vecs[4] = mkVec(2, 16'h0000, 16'h0F00, 16'h0, 16'h0, 0, 7'd20, 15'h7000, 1'b0);
    vecs[5] = mkVec(3, 16'h0000, 16'h0000, 16'h0003, 16'h0, 0, 7'd46, 15'h4000, 1'b0);
    vecs[6] = mkVec(4, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 7'd63, 15'h0000, 1'b0);
    vecs[7] = mkVec(1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 1, 7'd0,  15'h7FFF, 1'b0);
    vecAfterReset = mkVec(1, 16'h0100, 16'h0, 16'h0, 16'h0, 0, 7'd7, 15'h0000, 1'b0);

    rst       = 1'b0;
    en        = 1'b0;
    rnd_in    = 16'h0;
    rnd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_lzd", 32'(LZDout), 32'd0);
    checkOutput("rst_frac", 32'(frac), 32'd0);
    checkOutput("rst_all_zero", 32'(all_zero), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(rnd_ready), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset while one zero word has been absorbed must drop the partial count.
    waitIdle();
    en = 1'b1;
    @(posedge clk); #1;
    en        = 1'b0;
    rnd_in    = 16'h0000;
    rnd_valid = 1'b1;
    @(posedge clk); #1;
    rnd_valid = 1'b0;
    rst       = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midrst_lzd", 32'(LZDout), 32'd0);
    checkOutput("midrst_frac", 32'(frac), 32'd0);
    checkOutput("midrst_all_zero", 32'(all_zero), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_ready", 32'(rnd_ready), 32'd0);
    rst = 1'b1;
    applyStimulus(vecAfterReset);

    // en held high: a new detection every three cycles.
    waitIdle();
    rnd_in    = 16'h4000;
    rnd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expQ.push_back('{lzd: 7'd1, frac: 15'h0000, allZero: 1'b0});
    end
    en = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    checkOutput("cont_first_done", 32'(done), 32'd1);
    for (int k = 1; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        checkOutput("cont_gap", 32'(done), 32'd0);
      end
      @(negedge clk);
      checkOutput("cont_period", 32'(done), 32'd1);
    end
    en        = 1'b0;
    rnd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("cont_stop_busy", 32'(busy), 32'd0);
    checkOutput("cont_hold_lzd", 32'(LZDout), 32'd1);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
